// File: rtl/txt_pkg.sv
// Shared types and constants for the text page buffer.
// TXT_PAGE2_EN widens the page index from 10 to 11 bits (two text pages).
package txt_pkg;

  localparam logic [15:0] TXT_BASE   = 16'h0400;
  localparam int          TXT_BYTES  = 1024;
  localparam logic [7:0]  FILL_SPACE = 8'hA0;

`ifdef TXT_PAGE2_EN
  localparam int TXT_IDX_W = 11;
`else
  localparam int TXT_IDX_W = 10;
`endif
  localparam int TXT_WIN_BYTES = 1 << TXT_IDX_W;

  typedef logic [TXT_IDX_W-1:0] txt_idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } buf_state_t;

  typedef struct packed {
    txt_idx_t    idx;
    logic [7:0]  data;
  } wr_req_t;

  // True when base <= adr < base + bytes, without 16-bit wraparound.
  function automatic logic in_win(input logic [15:0] adr, input logic [15:0] base,
                                  input int unsigned bytes);
    logic [16:0] off;
    off = {1'b0, adr} - {1'b0, base};
    return (off[16] == 1'b0) && (off < 17'(bytes));
  endfunction

endpackage

// File: rtl/txt_wr_fifo.sv
// Synchronous FIFO of queued CPU text writes; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module txt_wr_fifo
  import txt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    res,
  input  logic    push_i,
  input  wr_req_t din_i,
  input  logic    pop_i,
  output wr_req_t dout_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wr_req_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == {CW{1'b0}});
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!res) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/txt_page_buf.sv
// 40x24 text page RAM fed by snooped CPU writes, with a renderer read port
// and clear-screen engine. Define TXT_PAGE2_EN for the two-page 2 KiB variant.
module txt_page_buf
  import txt_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADR   = TXT_BASE,
  parameter logic [7:0]  FILL_CHAR  = FILL_SPACE
) (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] cpu_adr,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_we,
  input  logic        txt_rd,
  input  logic [15:0] txt_adr,
`ifdef TXT_PAGE2_EN
  input  logic        page2,
`endif
  output logic [7:0]  txt_q,
  output logic        txt_vld,
  input  logic        clr,
  output logic        busy,
  output logic        fifo_full,
  output logic        ovf
);

  buf_state_t  state_q, state_d;
  txt_idx_t    clr_cnt_q, clr_cnt_d;
  logic [7:0]  mem_q [TXT_WIN_BYTES];
  logic [7:0]  ram_q;
  logic        rd_pend_q, rd_fill_q;
  logic [7:0]  txt_q_q;
  logic        txt_vld_q, ovf_q;

  logic        cpu_hit, rd_hit, push, pop, fifo_empty;
  txt_idx_t    rd_idx;
  wr_req_t     fifo_din, fifo_dout;
  logic        ram_we, ram_re;
  txt_idx_t    ram_idx;
  logic [7:0]  ram_wdata;

  assign cpu_hit       = in_win(cpu_adr, BASE_ADR, TXT_WIN_BYTES);
  assign rd_hit        = in_win(txt_adr, BASE_ADR, TXT_WIN_BYTES);
  assign fifo_din.idx  = txt_idx_t'(cpu_adr - BASE_ADR);
  assign fifo_din.data = cpu_d;
`ifdef TXT_PAGE2_EN
  assign rd_idx = {page2, txt_adr[9:0]};
`else
  assign rd_idx = txt_adr[9:0];
`endif

  assign push = cpu_we && cpu_hit;
  assign pop  = !txt_rd && (state_q == IDLE) && !fifo_empty;

  txt_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .res     (res),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM state register and clear address counter.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // FSM next state: a clear sweeps every RAM index once, then returns to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          state_d   = IDLE;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + txt_idx_t'(1);
        if (&clr_cnt_q) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // FSM outputs: single RAM port, clear write > renderer read > FIFO drain.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_idx   = '0;
    ram_wdata = 8'h00;
    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_idx   = clr_cnt_q;
        ram_wdata = FILL_CHAR;
      end
      IDLE: begin
        if (txt_rd) begin
          ram_re  = 1'b1;
          ram_idx = rd_idx;
        end else if (pop) begin
          ram_we    = 1'b1;
          ram_idx   = fifo_dout.idx;
          ram_wdata = fifo_dout.data;
        end else begin
          ram_idx = '0;
        end
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  // Page RAM; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= ram_wdata;
    end else if (ram_re) begin
      ram_q <= mem_q[ram_idx];
    end
  end

  // Two-stage read return; out-of-window or mid-clear reads yield FILL_CHAR.
  always_ff @(posedge clk) begin
    if (!res) begin
      rd_pend_q <= 1'b0;
      rd_fill_q <= 1'b0;
      txt_vld_q <= 1'b0;
      txt_q_q   <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      rd_pend_q <= txt_rd;
      rd_fill_q <= (state_q == CLEAR) || !rd_hit;
      txt_vld_q <= rd_pend_q;
      if (rd_pend_q) txt_q_q <= rd_fill_q ? FILL_CHAR : ram_q;
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign txt_q   = txt_q_q;
  assign txt_vld = txt_vld_q;
  assign busy    = (state_q == CLEAR);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_txt_page_buf.sv
// Directed self-checking bench for txt_page_buf (default single-page build).
module tb_txt_page_buf;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [15:0] cpu_adr = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_we = 1'b0;
  logic        txt_rd = 1'b0;
  logic [15:0] txt_adr = 16'h0000;
`ifdef TXT_PAGE2_EN
  logic        page2 = 1'b0;
`endif
  logic [7:0]  txt_q;
  logic        txt_vld;
  logic        clr = 1'b0;
  logic        busy, fifo_full, ovf;

  int n_chk = 0;
  int n_bad = 0;
  int n_cyc;

  txt_page_buf dut (
    .clk       (clk),
    .res       (res),
    .cpu_adr   (cpu_adr),
    .cpu_d     (cpu_d),
    .cpu_we    (cpu_we),
    .txt_rd    (txt_rd),
    .txt_adr   (txt_adr),
`ifdef TXT_PAGE2_EN
    .page2     (page2),
`endif
    .txt_q     (txt_q),
    .txt_vld   (txt_vld),
    .clr       (clr),
    .busy      (busy),
    .fifo_full (fifo_full),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] adr, input logic [7:0] exp);
    txt_rd  = 1'b1;
    txt_adr = adr;
    tick();
    txt_rd  = 1'b0;
    tick();
    chk_eq({tag, "_vld"}, 32'(txt_vld), 32'd1);
    chk_eq({tag, "_q"}, 32'(txt_q), 32'(exp));
    tick();
    chk_eq({tag, "_vld_drop"}, 32'(txt_vld), 32'd0);
    chk_eq({tag, "_q_hold"}, 32'(txt_q), 32'(exp));
  endtask

  task automatic cpu_wr(input logic [15:0] adr, input logic [7:0] d);
    cpu_we  = 1'b1;
    cpu_adr = adr;
    cpu_d   = d;
    tick();
    cpu_we  = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    res = 1'b1;
    chk_eq("rst_txt_q", 32'(txt_q), 32'h0);
    chk_eq("rst_vld", 32'(txt_vld), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_full", 32'(fifo_full), 32'd0);
    chk_eq("rst_ovf", 32'(ovf), 32'd0);

    // initial clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_busy(n_cyc);
    chk_eq("clr1_cycles", 32'(n_cyc), 32'd1024);
    rd_chk("clr1_0400", 16'h0400, 8'hA0);
    rd_chk("clr1_05A8", 16'h05A8, 8'hA0);
    rd_chk("clr1_07F7", 16'h07F7, 8'hA0);

    // single write, then an out-of-window write
    cpu_wr(16'h0428, 8'hC1);
    tick();
    tick();
    rd_chk("wr_0428", 16'h0428, 8'hC1);
    cpu_wr(16'h0800, 8'h55);
    tick();
    tick();
    chk_eq("oow_ovf", 32'(ovf), 32'd0);
    chk_eq("oow_full", 32'(fifo_full), 32'd0);
    rd_chk("oow_rd0800", 16'h0800, 8'hA0);
    rd_chk("oow_0400", 16'h0400, 8'hA0);
    rd_chk("oow_rd03FF", 16'h03FF, 8'hA0);

    // overflow while reads starve the FIFO
    txt_rd  = 1'b1;
    txt_adr = 16'h0400;
    for (int i = 0; i < 5; i++) cpu_wr(16'h0430 + 16'(i), 8'h31 + 8'(i));
    chk_eq("ovf_full", 32'(fifo_full), 32'd1);
    chk_eq("ovf_set", 32'(ovf), 32'd1);
    txt_rd = 1'b0;
    repeat (6) tick();
    chk_eq("ovf_drained", 32'(fifo_full), 32'd0);
    chk_eq("ovf_sticky", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) rd_chk("ovf_land", 16'h0430 + 16'(i), 8'h31 + 8'(i));
    rd_chk("ovf_dropped", 16'h0434, 8'hA0);

    // later write to the same address wins
    cpu_wr(16'h0500, 8'h11);
    cpu_wr(16'h0500, 8'h22);
    tick();
    tick();
    rd_chk("same_adr", 16'h0500, 8'h22);

    // read during clear, then reset mid-clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_eq("clr2_busy", 32'(busy), 32'd1);
    rd_chk("clr2_rd0500", 16'h0500, 8'hA0);
    repeat (495) tick();
    chk_eq("clr2_busy_mid", 32'(busy), 32'd1);
    res    = 1'b0;
    txt_rd = 1'b1;
    tick();
    res    = 1'b1;
    txt_rd = 1'b0;
    chk_eq("abort_busy", 32'(busy), 32'd0);
    chk_eq("abort_vld", 32'(txt_vld), 32'd0);
    chk_eq("abort_q", 32'(txt_q), 32'h0);
    chk_eq("abort_full", 32'(fifo_full), 32'd0);
    chk_eq("abort_ovf", 32'(ovf), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_busy(n_cyc);
    chk_eq("clr3_cycles", 32'(n_cyc), 32'd1024);

    // clear and write in the same cycle: the write survives
    clr     = 1'b1;
    cpu_we  = 1'b1;
    cpu_adr = 16'h0400;
    cpu_d   = 8'hD8;
    tick();
    clr     = 1'b0;
    cpu_we  = 1'b0;
    wait_busy(n_cyc);
    chk_eq("clr4_cycles", 32'(n_cyc), 32'd1024);
    tick();
    rd_chk("clrwr_0400", 16'h0400, 8'hD8);
    rd_chk("clrwr_0401", 16'h0401, 8'hA0);
    rd_chk("clrwr_0428", 16'h0428, 8'hA0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
